seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. Drives one shared seven_seg_dec instance and selects one digit per time slot. Each slot has a blanking interval to suppress ghosting. New display values enter through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between the counter datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); data width is 4*NUM_DIGITS
SHOW_CYCLES, 100000, clk cycles a digit's anode is active per slot (>=1)
BLANK_CYCLES, 1000, clk cycles all anodes are off before each digit's show phase (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  scan enable; low forces display dark
data_in  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant
data_valid  in  1  data_in offered
data_ready  out  1  pending buffer empty; transfer occurs when data_valid && data_ready
dp_in  in  NUM_DIGITS  decimal point per digit, active-high
seg_out  out  7  segments {a,b,c,d,e,f,g}, active-low, from seven_seg_dec
dp_out  out  1  decimal point, active-low
an_out  out  NUM_DIGITS  anodes, active-low, at most one low at any time
digit_idx  out  ceil(log2(NUM_DIGITS)), min 1  index of current slot's digit
frame_done  out  1  one-cycle pulse when the last digit's show phase ends

Behaviour:
- Reset (async, immediate): state OFF; an_out all 1; seg_out 7'b1111111; dp_out 1; data_ready 1; frame_done 0; digit_idx 0; display register 0; pending buffer empty; counters 0.
- States:
  - OFF: entered on reset or when enable is low. Anodes off. digit_idx 0.
  - BLANK: lasts BLANK_CYCLES cycles. Anodes off. seg_out 1111111. dp_out 1.
  - SHOW: lasts SHOW_CYCLES cycles. an_out[digit_idx]=0. seg_out = decode(display nibble digit_idx). dp_out = ~dp_in[digit_idx].
- Transitions:
  - OFF -> BLANK(digit 0) on the first edge with enable=1.
  - BLANK -> SHOW(same digit) after the count expires.
  - SHOW -> BLANK(digit+1) after the count expires. From the last digit, digit wraps to 0.
  - enable low in any state -> OFF on the next edge. Counters and digit_idx are cleared; there is no frame_done.
- All display outputs are registered. Anode, segments and dp change on the same edge (no skew between them). seg_out is registered from the decoder output.
- Handshake:
  - data_ready = pending empty.
  - On transfer, pending <= data_in and pending becomes full.
- Commit (display register <= pending, pending emptied):
  - Occurs on the edge where frame_done is asserted, i.e. the SHOW -> BLANK transition out of digit NUM_DIGITS-1.
  - Also occurs in OFF on any edge, since there is no frame to tear.
- If a transfer and a commit coincide while pending is empty, the new data goes to pending and is committed at the next frame.
- dp_in is sampled live, not buffered.
- Frame period = NUM_DIGITS*(SHOW_CYCLES+BLANK_CYCLES) cycles. Counter widths are sized from the parameters; no overflow.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - During SHOW for digit k>0, if display nibbles k..NUM_DIGITS-1 are all zero, the anode stays off and seg_out stays 1111111.
  - dp_in[k] is ignored for such a blanked digit.
  - Digit 0 is always shown. Slot timing is unchanged.
- When undefined: every digit is shown, including leading zeros.

Test Plan:
(All cases use NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2.)
- Reset then enable=1: an_out stays 4'b1111 for 2 cycles, then 4'b1110 for 4 cycles, then blank for 2, then 4'b1101, and so on. frame_done pulses every 24 cycles.
- Transfer 16'h12AF mid-frame: display keeps its old value until frame_done. The next frame shows digit0 seg 0111000 (F), digit1 0001000 (A), digit2 0010010 (2), digit3 1001111 (1). data_ready is low from transfer until commit.
- Two back-to-back offers: the first is accepted; the second is held off (data_ready=0) until commit. Then it is accepted and shown one frame later.
- Transfer in the exact frame_done cycle with pending empty: the value is shown in the frame after next, not the next one.
- enable dropped while digit 2 is showing: the next edge gives an_out 4'b1111 and digit_idx 0. Re-enable restarts at BLANK, digit 0. An async rst pulse mid-SHOW forces all outputs to their reset values immediately.
- With LEADING_ZERO_BLANK_EN and value 16'h0050: digits 3 and 2 stay dark, digit 1 shows 0100100, digit 0 shows 0000001. Value 16'h0000 shows digit 0 only.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit seven-segment display. One shared decoder, one digit per slot,
// a blanking interval before every digit, and frame-boundary commit of new
// display values taken in through a valid/ready handshake.
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).

// Hex nibble to active-low segments {a,b,c,d,e,f,g}.
module seven_seg_dec (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Pure lookup; every input value is listed so no state is held.
  always_comb begin
    case (hex)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end
endmodule

module seven_seg_scan_ctrl #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int SHOW_CYCLES  = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int DW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [DW-1:0]           digit_idx,
  output logic                    frame_done
);

  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [4*NUM_DIGITS-1:0] pend_q;
  logic                    pend_full_q;
  logic                    xfer;
  logic                    commit;

  logic [3:0]              dec_nibble;
  logic [6:0]              dec_seg;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  // Slot sequencing: OFF -> BLANK(k) -> SHOW(k) -> BLANK(k+1) ...; enable low wins.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d   = ST_BLANK;
            cnt_d     = '0;
            frame_end = (digit_q == DIGIT_LAST);
            digit_d   = frame_end ? '0 : digit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // The shared decoder looks at the digit the next cycle will display, so its
  // result can be registered on the same edge as the anode.
  assign dec_nibble = disp_q[4*digit_d +: 4];

  seven_seg_dec u_dec (
    .hex (dec_nibble),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] hi_zero;

  // hi_zero[k] is set when nibbles k..NUM_DIGITS-1 of the display are all zero.
  always_comb begin
    hi_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hi_zero[k] = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (disp_q[4*j +: 4] != 4'h0) hi_zero[k] = 1'b0;
      end
    end
  end

  // Digit 0 is always lit so a zero value still shows "0".
  assign lz_blank = (digit_d != '0) && hi_zero[digit_d];
`else
  assign lz_blank = 1'b0;
`endif

  // Next display-pin values, derived from the next state so pins and state agree.
  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW && !lz_blank) begin
      an_d[digit_d] = 1'b0;
      seg_d         = dec_seg;
      dp_d          = ~dp_in[digit_d];
    end
  end

  // Scan state and registered display pins (all pins move on one edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      digit_q <= '0;
      an_out  <= '1;
      seg_out <= 7'b1111111;
      dp_out  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register here take its new
      // value from the pre-edge state, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      an_out  <= an_d;
      seg_out <= seg_d;
      dp_out  <= dp_d;
    end
  end

  // A transfer needs an empty pending buffer; a commit needs a full one, so the
  // two never collide on the same edge. Committing while OFF cannot tear a frame.
  assign xfer   = data_valid && !pend_full_q;
  assign commit = pend_full_q && ((state_q == ST_OFF) || frame_end);

  // Pending buffer and display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (commit) begin
      disp_q      <= pend_q;
      pend_full_q <= 1'b0;
    end else if (xfer) begin
      pend_q      <= data_in;
      pend_full_q <= 1'b1;
    end
  end

  assign data_ready = !pend_full_q;
  assign digit_idx  = digit_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (NUM_DIGITS=4, SHOW=4, BLANK=2).
// A frame-position model predicts every output each cycle; directed tests pin
// the model with hand-decoded segment patterns and anode timing.
module tb_seven_seg_scan_ctrl;

  localparam int N    = 4;
  localparam int S    = 4;
  localparam int B    = 2;
  localparam int SLOT = S + B;
  localparam int P    = N * SLOT;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        enable     = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in    = '0;
  logic [3:0]  dp_in      = 4'b0101;
  logic        data_ready;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SHOW_CYCLES  (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting, expected event never seen at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Display is a pure function of time since enable: position in the frame
  // picks the slot, position in the slot picks blank or show.
  bit          m_on   = 1'b0;
  int          m_t    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_full = 1'b0;
  bit          m_fd;
  bit          m_dark;
  int          pos, slot;
  logic [3:0]  nib;
  logic [3:0]  e_an  = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp  = 1'b1;
  logic [1:0]  e_idx = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 1'b0; m_t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
    end else begin
      m_fd = m_on && enable && ((m_t % P) == P - 1);
      if (m_full && (!m_on || m_fd)) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end else if (data_valid && !m_full) begin
        m_pend = data_in;
        m_full = 1'b1;
      end
      if (!enable)    begin m_on = 1'b0; m_t = 0; end
      else if (!m_on) begin m_on = 1'b1; m_t = 0; end
      else            m_t = m_t + 1;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0;
    if (m_on) begin
      pos   = m_t % P;
      slot  = pos / SLOT;
      e_idx = 2'(slot);
      nib   = 4'(m_disp >> (4 * slot));
`ifdef LEADING_ZERO_BLANK_EN
      m_dark = (slot > 0) && ((m_disp >> (4 * slot)) == 0);
`else
      m_dark = 1'b0;
`endif
      if ((pos % SLOT) >= B && !m_dark) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = SEG_TAB[nib];
        e_dp  = ~dp_in[slot];
      end
    end
  end

  // Compare every cycle, half a period after the edge.
  always @(negedge clk) begin
    check("an_out",     an_out,     e_an);
    check("seg_out",    seg_out,    e_seg);
    check("dp_out",     dp_out,     e_dp);
    check("digit_idx",  digit_idx,  e_idx);
    check("data_ready", data_ready, !m_full);
    check("frame_done", frame_done, m_on && enable && ((m_t % P) == P - 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd(input int budget, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin tick(); n++; end
    if (frame_done !== 1'b1) timeout_fail("wait_frame_done");
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget);
    int n = 0;
    while (an_out !== target && n < budget) begin tick(); n++; end
    if (an_out !== target) timeout_fail("wait_anode");
  endtask

  task automatic offer(input logic [15:0] d, input int budget);
    int n = 0;
    data_valid = 1'b1;
    data_in    = d;
    while (data_ready !== 1'b1 && n < budget) begin tick(); n++; end
    if (data_ready !== 1'b1) timeout_fail("offer_ready");
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int bad;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    check("rst_an",    an_out,     4'hF);
    check("rst_seg",   seg_out,    7'b1111111);
    check("rst_dp",    dp_out,     1'b1);
    check("rst_ready", data_ready, 1'b1);
    check("rst_fd",    frame_done, 1'b0);
    check("rst_idx",   digit_idx,  2'd0);

    // Scan timing from enable.
    enable = 1'b1;
    tick(); check("blank0_a", an_out, 4'hF);
    tick(); check("blank0_b", an_out, 4'hF);
    tick(); check("show0", an_out, 4'hE); check("show0_idx", digit_idx, 2'd0);
    repeat (3) tick(); check("show0_end", an_out, 4'hE);
    tick(); check("blank1", an_out, 4'hF); check("blank1_idx", digit_idx, 2'd1);
    repeat (2) tick(); check("show1", an_out, 4'hD);

    wait_fd(60, n); tick(); wait_fd(60, n);
    check("frame_period", n + 1, P);

    // Mid-frame transfer, visible only after the frame boundary.
    repeat (5) tick();
    offer(16'h12AF, 60);
    check("ready_low_after_xfer", data_ready, 1'b0);
    wait_fd(60, n); tick();
    wait_an(4'hE, 30); check("seg_d0_F", seg_out, 7'b0111000); check("dp_d0", dp_out, 1'b0);
    wait_an(4'hD, 30); check("seg_d1_A", seg_out, 7'b0001000); check("dp_d1", dp_out, 1'b1);
    wait_an(4'hB, 30); check("seg_d2_2", seg_out, 7'b0010010);
    wait_an(4'h7, 30); check("seg_d3_1", seg_out, 7'b1001111);
    check("ready_after_commit", data_ready, 1'b1);

    // Back-to-back offers: the second waits for the commit of the first.
    offer(16'h3456, 60);
    check("ready_low_b2b", data_ready, 1'b0);
    offer(16'h789C, 60);
    check("ready_low_second", data_ready, 1'b0);
    wait_an(4'hE, 30); check("seg_first_6", seg_out, 7'b0100000);
    wait_fd(60, n); tick();
    wait_an(4'hE, 30); check("seg_second_C", seg_out, 7'b0110001);

    // Transfer in the frame_done cycle: shown in the frame after next.
    wait_fd(60, n);
    data_valid = 1'b1; data_in = 16'hBCDE;
    tick();
    data_valid = 1'b0;
    check("ready_low_fd_xfer", data_ready, 1'b0);
    wait_an(4'hE, 30); check("seg_still_C", seg_out, 7'b0110001);
    wait_fd(60, n); tick();
    wait_an(4'hE, 30); check("seg_now_E", seg_out, 7'b0110000);

    // Enable dropped while digit 2 shows.
    wait_an(4'hB, 60);
    enable = 1'b0;
    tick(); check("dis_an", an_out, 4'hF); check("dis_idx", digit_idx, 2'd0);
    enable = 1'b1;
    tick(); check("reen_an", an_out, 4'hF); check("reen_idx", digit_idx, 2'd0);
    repeat (2) tick(); check("reen_show0", an_out, 4'hE); check("reen_seg", seg_out, 7'b0110000);

    // Asynchronous reset mid-SHOW with pending full.
    offer(16'h4321, 60);
    check("ready_low_pre_rst", data_ready, 1'b0);
    wait_an(4'hD, 30);
    #1 rst = 1'b1;
    #1;
    check("arst_an",    an_out,     4'hF);
    check("arst_seg",   seg_out,    7'b1111111);
    check("arst_dp",    dp_out,     1'b1);
    check("arst_ready", data_ready, 1'b1);
    check("arst_idx",   digit_idx,  2'd0);
    check("arst_fd",    frame_done, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    wait_an(4'hE, 30); check("seg_after_rst_0", seg_out, 7'b0000001);

    // Leading zeros.
    offer(16'h0050, 60);
    wait_fd(60, n); tick();
`ifdef LEADING_ZERO_BLANK_EN
    wait_an(4'hE, 30); check("lz_d0", seg_out, 7'b0000001);
    wait_an(4'hD, 30); check("lz_d1", seg_out, 7'b0100100);
    bad = 0;
    for (int i = 0; i < P; i++) begin
      if (an_out == 4'hB || an_out == 4'h7) bad++;
      tick();
    end
    check("lz_dark_23", bad, 0);
    offer(16'h0000, 60);
    wait_fd(60, n); tick();
    bad = 0;
    for (int i = 0; i < P; i++) begin
      if (an_out != 4'hF && an_out != 4'hE) bad++;
      tick();
    end
    check("lz_zero_only_d0", bad, 0);
`else
    bad = 0;
    wait_an(4'hD, 30); check("nolz_d1", seg_out, 7'b0100100);
    wait_an(4'hB, 30); check("nolz_d2", seg_out, 7'b0000001);
    wait_an(4'h7, 30); check("nolz_d3", seg_out, 7'b0000001);
    check("nolz_bad", bad, 0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
